// File: rtl/pong_pkg.sv
// Shared Pong geometry, colours and game states, used by both the motion
// engine and the pixel generator so that collisions match what is drawn.
package pong_pkg;

  localparam int WALL_TOP_FIRST = 3;
  localparam int WALL_TOP_LAST  = 5;
  localparam int WALL_BOT_FIRST = 475;
  localparam int WALL_BOT_LAST  = 477;
  localparam int FIELD_TOP      = WALL_TOP_LAST + 1;
  localparam int FIELD_BOT      = WALL_BOT_FIRST - 1;

  localparam int LPAD_X_LEFT    = 10;
  localparam int LPAD_X_RIGHT   = 16;
  localparam int RPAD_X_LEFT    = 624;
  localparam int RPAD_X_RIGHT   = 630;

  localparam int BALL_SIZE      = 7;
  localparam int PAD_WIDTH      = 7;
  localparam int PAD_HEIGHT     = 19;

  localparam int BALL_X_CENTRE  = 317;
  localparam int BALL_Y_CENTRE  = 237;
  localparam int PAD_Y_CENTRE   = 231;

  localparam int PAD_Y_MIN      = FIELD_TOP;
  localparam int PAD_Y_MAX      = FIELD_BOT - PAD_HEIGHT + 1;
  localparam int BALL_Y_MIN     = FIELD_TOP;
  localparam int BALL_Y_MAX     = FIELD_BOT - BALL_SIZE + 1;

  // Ball x positions that put it flush against a paddle face
  localparam int BALL_X_HIT_L   = LPAD_X_RIGHT + 1;
  localparam int BALL_X_HIT_R   = RPAD_X_LEFT - BALL_SIZE;
  localparam int MISS_X_L       = 2;
  localparam int MISS_X_R       = 632;

  localparam logic [11:0] COLOR_BG     = 12'h000;
  localparam logic [11:0] COLOR_WALL   = 12'hFFF;
  localparam logic [11:0] COLOR_PADDLE = 12'h0F0;
  localparam logic [11:0] COLOR_BALL   = 12'hFF0;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    SCORED,
    OVER
  } state_e;

endpackage

// File: rtl/pong_motion_paddle_ctrl.sv
// One paddle: steps up or down once per frame tick, clamped to the field.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PAD_SPEED = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       up,
  input  logic       dn,
  input  logic       freeze,
  output logic [9:0] y
);

  localparam logic [9:0] STEP  = 10'(PAD_SPEED);
  localparam logic [9:0] Y_MIN = 10'(PAD_Y_MIN);
  localparam logic [9:0] Y_MAX = 10'(PAD_Y_MAX);
  localparam logic [9:0] Y_RST = 10'(PAD_Y_CENTRE);

  logic [9:0] y_q, y_d;

  // Compare before stepping so the unsigned arithmetic never wraps
  always_comb begin
    y_d = y_q;
    if (tick && !freeze) begin
      if (up && !dn) begin
        y_d = (y_q < Y_MIN + STEP) ? Y_MIN : y_q - STEP;
      end else if (dn && !up) begin
        y_d = (y_q > Y_MAX - STEP) ? Y_MAX : y_q + STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= Y_RST;
    else     y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/pong_motion.sv
// Frame-locked Pong game state: ball motion and bounces, scoring, the
// serve / point pause / game-over sequence, and the two paddles.
module pong_motion
  import pong_pkg::*;
#(
  parameter int BALL_SPEED   = 2,
  parameter int PAD_SPEED    = 4,
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] lpad_y,
  output logic [9:0] rpad_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam logic signed [10:0] STEP     = 11'(BALL_SPEED);
  localparam logic signed [10:0] Y_MIN    = 11'(BALL_Y_MIN);
  localparam logic signed [10:0] Y_MAX    = 11'(BALL_Y_MAX);
  localparam logic signed [10:0] HIT_L    = 11'(BALL_X_HIT_L);
  localparam logic signed [10:0] HIT_R    = 11'(BALL_X_HIT_R);
  localparam logic signed [10:0] FACE_L   = 11'(LPAD_X_RIGHT);
  localparam logic signed [10:0] FACE_R   = 11'(RPAD_X_LEFT);
  localparam logic signed [10:0] MISS_L   = 11'(MISS_X_L);
  localparam logic signed [10:0] MISS_R   = 11'(MISS_X_R);
  localparam logic signed [10:0] BALL_EXT = 11'(BALL_SIZE - 1);
  localparam logic signed [10:0] PAD_EXT  = 11'(PAD_HEIGHT - 1);
  localparam logic [9:0]         X_CTR    = 10'(BALL_X_CENTRE);
  localparam logic [9:0]         Y_CTR    = 10'(BALL_Y_CENTRE);
  localparam logic [3:0]         WIN      = 4'(WIN_SCORE);
  localparam logic [7:0]         PAUSE    = 8'(PAUSE_FRAMES);

  state_e     state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [7:0] pause_q, pause_d;
  logic       serve_pending_q, serve_pending_d;
  logic       game_over_q, game_over_d;

  logic signed [10:0] bx, nx, ny;
  logic hit_l, hit_r, miss_l, miss_r, restart, pad_rst, pad_freeze;

  function automatic logic overlaps(input logic signed [10:0] top, input logic [9:0] pad);
    logic signed [10:0] p;
    p = $signed({1'b0, pad});
    return (top + BALL_EXT >= p) && (top <= p + PAD_EXT);
  endfunction

  // Collision tests use the paddle rows registered before this tick
  assign bx     = $signed({1'b0, ball_x_q});
  assign nx     = dx_q ? bx + STEP : bx - STEP;
  assign ny     = dy_q ? $signed({1'b0, ball_y_q}) + STEP : $signed({1'b0, ball_y_q}) - STEP;
  assign hit_l  = !dx_q && (bx >= HIT_L) && (nx <= FACE_L) && overlaps(ny, lpad_y);
  assign hit_r  = dx_q && (bx + BALL_EXT < FACE_R) && (nx + BALL_EXT >= FACE_R) && overlaps(ny, rpad_y);
  assign miss_l = !dx_q && !hit_l && (nx < MISS_L);
  assign miss_r = dx_q && !hit_r && (nx > MISS_R);

  assign restart    = frame_tick && (state_q == OVER) && serve_pending_q;
  assign pad_rst    = rst || restart;
  assign pad_freeze = (state_q == OVER);

  always_comb begin
    state_d         = state_q;
    ball_x_d        = ball_x_q;
    ball_y_d        = ball_y_q;
    dx_d            = dx_q;
    dy_d            = dy_q;
    score_l_d       = score_l_q;
    score_r_d       = score_r_q;
    pause_d         = pause_q;
    serve_pending_d = 1'b0;

    // A serve arriving with a tick is kept for the following tick
    if (state_q == SERVE || state_q == OVER) begin
      serve_pending_d = frame_tick ? 1'b0 : serve_pending_q;
      if (serve) serve_pending_d = 1'b1;
    end

    if (frame_tick) begin
      case (state_q)
        SERVE: begin
          ball_x_d = X_CTR;
          ball_y_d = Y_CTR;
          if (serve_pending_q) state_d = PLAY;
        end
        PLAY: begin
          if (ny < Y_MIN) begin
            ball_y_d = Y_MIN[9:0];
            dy_d     = 1'b1;
          end else if (ny > Y_MAX) begin
            ball_y_d = Y_MAX[9:0];
            dy_d     = 1'b0;
          end else begin
            ball_y_d = ny[9:0];
          end
          if (hit_l) begin
            ball_x_d = HIT_L[9:0];
            dx_d     = 1'b1;
          end else if (hit_r) begin
            ball_x_d = HIT_R[9:0];
            dx_d     = 1'b0;
          end else begin
            ball_x_d = nx[9:0];
          end
          // On a miss the ball freezes where it was, aimed at the loser
          if (miss_l || miss_r) begin
            ball_x_d = ball_x_q;
            ball_y_d = ball_y_q;
            dy_d     = dy_q;
            dx_d     = miss_r;
            pause_d  = PAUSE;
            state_d  = SCORED;
            if (miss_l) begin
              score_r_d = score_r_q + 4'd1;
              if (score_r_q + 4'd1 == WIN) state_d = OVER;
            end else begin
              score_l_d = score_l_q + 4'd1;
              if (score_l_q + 4'd1 == WIN) state_d = OVER;
            end
          end
        end
        SCORED: begin
          pause_d = pause_q - 8'd1;
          if (pause_q <= 8'd1) begin
            pause_d  = 8'd0;
            ball_x_d = X_CTR;
            ball_y_d = Y_CTR;
            state_d  = SERVE;
          end
        end
        OVER: begin
          if (serve_pending_q) begin
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            ball_x_d  = X_CTR;
            ball_y_d  = Y_CTR;
            dx_d      = 1'b1;
            dy_d      = 1'b1;
            pause_d   = 8'd0;
            state_d   = SERVE;
          end
        end
      endcase
    end

    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= SERVE;
      ball_x_q        <= X_CTR;
      ball_y_q        <= Y_CTR;
      dx_q            <= 1'b1;
      dy_q            <= 1'b1;
      score_l_q       <= 4'd0;
      score_r_q       <= 4'd0;
      pause_q         <= 8'd0;
      serve_pending_q <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      ball_x_q        <= ball_x_d;
      ball_y_q        <= ball_y_d;
      dx_q            <= dx_d;
      dy_q            <= dy_d;
      score_l_q       <= score_l_d;
      score_r_q       <= score_r_d;
      pause_q         <= pause_d;
      serve_pending_q <= serve_pending_d;
      game_over_q     <= game_over_d;
    end
  end

  paddle_ctrl #(.PAD_SPEED(PAD_SPEED)) u_lpad (
    .clk    (clk),
    .rst    (pad_rst),
    .tick   (frame_tick),
    .up     (l_up),
    .dn     (l_dn),
    .freeze (pad_freeze),
    .y      (lpad_y)
  );

  paddle_ctrl #(.PAD_SPEED(PAD_SPEED)) u_rpad (
    .clk    (clk),
    .rst    (pad_rst),
    .tick   (frame_tick),
    .up     (r_up),
    .dn     (r_dn),
    .freeze (pad_freeze),
    .y      (rpad_y)
  );

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_motion.sv
// Directed bench for pong_motion with WIN_SCORE=2 so a full game fits in a
// short run; every expected coordinate is worked out by hand from the geometry.
module tb_pong_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] ball_x, ball_y, lpad_y, rpad_y;
  logic [3:0] score_l, score_r;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  pong_motion #(
    .BALL_SPEED   (2),
    .PAD_SPEED    (4),
    .WIN_SCORE    (2),
    .PAUSE_FRAMES (60)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .l_up       (l_up),
    .l_dn       (l_dn),
    .r_up       (r_up),
    .r_dn       (r_dn),
    .serve      (serve),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .lpad_y     (lpad_y),
    .rpad_y     (rpad_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Guards against a hung run; never reached in a normal sequence
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; results are read on the next falling edge
  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_serve();
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ball_x, ball_y} !== {10'd317, 10'd237}) begin
      $display("[TB] FAIL reset_ball got %0d/%0d expected 317/237", ball_x, ball_y); errors++;
    end
    checks++;
    if ({lpad_y, rpad_y} !== {10'd231, 10'd231}) begin
      $display("[TB] FAIL reset_pads got %0d/%0d expected 231/231", lpad_y, rpad_y); errors++;
    end
    checks++;
    if ({score_l, score_r, game_over} !== 9'd0) begin
      $display("[TB] FAIL reset_scores got %0d/%0d over=%0b expected 0/0 over=0", score_l, score_r, game_over); errors++;
    end
  endtask

  task automatic test_idle_serve();
    run_ticks(10);
    checks++;
    if ({ball_x, ball_y} !== {10'd317, 10'd237}) begin
      $display("[TB] FAIL idle_ball got %0d/%0d expected 317/237", ball_x, ball_y); errors++;
    end
    checks++;
    if ({lpad_y, rpad_y, game_over} !== {10'd231, 10'd231, 1'b0}) begin
      $display("[TB] FAIL idle_pads got %0d/%0d over=%0b expected 231/231 over=0", lpad_y, rpad_y, game_over); errors++;
    end
  endtask

  task automatic test_paddle_clamp();
    l_up = 1'b1;
    do_tick();
    checks++;
    if (lpad_y !== 10'd227) begin
      $display("[TB] FAIL lpad_step1 got %0d expected 227", lpad_y); errors++;
    end
    do_tick();
    checks++;
    if (lpad_y !== 10'd223) begin
      $display("[TB] FAIL lpad_step2 got %0d expected 223", lpad_y); errors++;
    end
    run_ticks(98);
    checks++;
    if (lpad_y !== 10'd6) begin
      $display("[TB] FAIL lpad_top_clamp got %0d expected 6", lpad_y); errors++;
    end
    l_dn = 1'b1;
    run_ticks(5);
    checks++;
    if (lpad_y !== 10'd6) begin
      $display("[TB] FAIL lpad_both_hold got %0d expected 6", lpad_y); errors++;
    end
    l_up = 1'b0;
    l_dn = 1'b0;
    checks++;
    if (rpad_y !== 10'd231) begin
      $display("[TB] FAIL rpad_untouched got %0d expected 231", rpad_y); errors++;
    end
    r_dn = 1'b1;
    run_ticks(100);
    r_dn = 1'b0;
    checks++;
    if (rpad_y !== 10'd456) begin
      $display("[TB] FAIL rpad_bottom_clamp got %0d expected 456", rpad_y); errors++;
    end
  endtask

  // Right paddle parked at 383 so the ball, falling back from the floor, hits it
  task automatic test_play_bounce();
    int ks [13] = '{1, 2, 115, 116, 117, 150, 151, 152, 348, 349, 451, 452, 453};
    int ex [13] = '{319, 321, 547, 549, 551, 617, 617, 615, 223, 221, 17, 17, 19};
    int ey [13] = '{239, 241, 467, 468, 466, 400, 398, 396, 6, 8, 212, 214, 216};
    do_reset();
    r_dn = 1'b1;
    run_ticks(38);
    r_dn = 1'b0;
    checks++;
    if (rpad_y !== 10'd383) begin
      $display("[TB] FAIL rpad_park got %0d expected 383", rpad_y); errors++;
    end
    pulse_serve();
    do_tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd317, 10'd237}) begin
      $display("[TB] FAIL serve_tick got %0d/%0d expected 317/237", ball_x, ball_y); errors++;
    end
    for (int k = 1; k <= 453; k++) begin
      l_up = (k >= 200 && k <= 202);
      do_tick();
      for (int i = 0; i < 13; i++) begin
        if (ks[i] == k) begin
          checks++;
          if (ball_x !== 10'(ex[i]) || ball_y !== 10'(ey[i])) begin
            $display("[TB] FAIL play_k%0d got %0d/%0d expected %0d/%0d", k, ball_x, ball_y, ex[i], ey[i]);
            errors++;
          end
        end
      end
      if (k == 203) begin
        checks++;
        if (lpad_y !== 10'd219) begin
          $display("[TB] FAIL lpad_in_play got %0d expected 219", lpad_y); errors++;
        end
      end
    end
    l_up = 1'b0;
  endtask

  // Right paddle at the top, ball low: right miss, pause, recentre
  task automatic test_miss_and_pause();
    do_reset();
    r_up = 1'b1;
    run_ticks(57);
    r_up = 1'b0;
    checks++;
    if (rpad_y !== 10'd6) begin
      $display("[TB] FAIL rpad_to_top got %0d expected 6", rpad_y); errors++;
    end
    pulse_serve();
    do_tick();
    for (int k = 1; k <= 158; k++) begin
      do_tick();
      if (k == 157) begin
        checks++;
        if (ball_x !== 10'd631 || score_l !== 4'd0) begin
          $display("[TB] FAIL pre_miss got x=%0d score_l=%0d expected x=631 score_l=0", ball_x, score_l); errors++;
        end
      end
    end
    checks++;
    if ({score_l, score_r, game_over} !== {4'd1, 4'd0, 1'b0}) begin
      $display("[TB] FAIL right_miss got %0d/%0d over=%0b expected 1/0 over=0", score_l, score_r, game_over); errors++;
    end
    run_ticks(59);
    checks++;
    if (!(ball_x > 10'd600) || score_l !== 4'd1) begin
      $display("[TB] FAIL pause_frozen got x=%0d score_l=%0d expected x>600 score_l=1", ball_x, score_l); errors++;
    end
    do_tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd317, 10'd237}) begin
      $display("[TB] FAIL recentre got %0d/%0d expected 317/237", ball_x, ball_y); errors++;
    end
    pulse_serve();
    do_tick();
    do_tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd319, 10'd235}) begin
      $display("[TB] FAIL reserve_dir got %0d/%0d expected 319/235", ball_x, ball_y); errors++;
    end
  endtask

  // Continues from the re-serve: second right miss reaches WIN_SCORE=2
  task automatic test_game_over();
    for (int k = 2; k <= 158; k++) begin
      do_tick();
      if (k == 116) begin
        checks++;
        if ({ball_x, ball_y} !== {10'd549, 10'd6}) begin
          $display("[TB] FAIL top_wall got %0d/%0d expected 549/6", ball_x, ball_y); errors++;
        end
      end
      if (k == 157) begin
        checks++;
        if (game_over !== 1'b0 || score_l !== 4'd1) begin
          $display("[TB] FAIL pre_over got over=%0b score_l=%0d expected over=0 score_l=1", game_over, score_l); errors++;
        end
      end
    end
    checks++;
    if ({game_over, score_l, score_r} !== {1'b1, 4'd2, 4'd0}) begin
      $display("[TB] FAIL over_entry got over=%0b %0d/%0d expected over=1 2/0", game_over, score_l, score_r); errors++;
    end
    r_dn = 1'b1;
    run_ticks(3);
    r_dn = 1'b0;
    checks++;
    if (rpad_y !== 10'd6 || game_over !== 1'b1) begin
      $display("[TB] FAIL over_frozen got rpad=%0d over=%0b expected rpad=6 over=1", rpad_y, game_over); errors++;
    end
    pulse_serve();
    do_tick();
    checks++;
    if ({score_l, score_r, game_over} !== 9'd0) begin
      $display("[TB] FAIL restart_scores got %0d/%0d over=%0b expected 0/0 over=0", score_l, score_r, game_over); errors++;
    end
    checks++;
    if ({ball_x, ball_y, lpad_y, rpad_y} !== {10'd317, 10'd237, 10'd231, 10'd231}) begin
      $display("[TB] FAIL restart_pos got %0d/%0d pads %0d/%0d expected 317/237 pads 231/231", ball_x, ball_y, lpad_y, rpad_y); errors++;
    end
  endtask

  // Serve coinciding with a tick only takes effect on the tick after
  task automatic test_serve_same_tick();
    @(negedge clk);
    serve = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    serve = 1'b0;
    frame_tick = 1'b0;
    do_tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd317, 10'd237}) begin
      $display("[TB] FAIL same_tick_serve got %0d/%0d expected 317/237", ball_x, ball_y); errors++;
    end
    do_tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd319, 10'd239}) begin
      $display("[TB] FAIL first_move got %0d/%0d expected 319/239", ball_x, ball_y); errors++;
    end
  endtask

  // Three consecutive tick cycles, then reset together with tick and button
  task automatic test_back_to_back_and_reset();
    @(negedge clk);
    frame_tick = 1'b1;
    l_up = 1'b1;
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
    l_up = 1'b0;
    checks++;
    if ({ball_x, ball_y, lpad_y} !== {10'd325, 10'd245, 10'd219}) begin
      $display("[TB] FAIL back_to_back got %0d/%0d lpad=%0d expected 325/245 lpad=219", ball_x, ball_y, lpad_y); errors++;
    end
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    l_up = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    l_up = 1'b0;
    checks++;
    if ({ball_x, ball_y, lpad_y, rpad_y} !== {10'd317, 10'd237, 10'd231, 10'd231}) begin
      $display("[TB] FAIL rst_mid_play got %0d/%0d pads %0d/%0d expected 317/237 pads 231/231", ball_x, ball_y, lpad_y, rpad_y); errors++;
    end
    checks++;
    if ({score_l, score_r, game_over} !== 9'd0) begin
      $display("[TB] FAIL rst_mid_play_scores got %0d/%0d over=%0b expected 0/0 over=0", score_l, score_r, game_over); errors++;
    end
    do_tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd317, 10'd237}) begin
      $display("[TB] FAIL rst_back_to_serve got %0d/%0d expected 317/237", ball_x, ball_y); errors++;
    end
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    $display("[TB] pong_motion directed bench starting");
    test_reset();
    test_idle_serve();
    test_paddle_clamp();
    test_play_bounce();
    test_miss_and_pause();
    test_game_over();
    test_serve_same_tick();
    test_back_to_back_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
